// File: rtl/rd_port_arbiter_pkg.sv
// Shared definitions for the per-source read-port arbiter: default sizing,
// source lock state encoding and a width helper.
package rd_port_arbiter_pkg;

    localparam int PORT_NUB_TOTAL = 4;
    localparam int PKG_DATA_WIDTH = 16;

    typedef enum logic {
        SRC_FREE   = 1'b0,
        SRC_LOCKED = 1'b1
    } src_state_e;

    // Index width that stays at least one bit wide for single-entry sets.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rd_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first asserted request at or after ptr,
// searching cyclically. Works for any N, not only powers of two.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt_oh,
    output logic [IDX_W-1:0] gnt_idx
);

    int               c;
    logic [IDX_W-1:0] cidx;
    logic             found;

    always_comb begin
        gnt_oh  = '0;
        gnt_idx = '0;
        found   = 1'b0;
        c       = 0;
        cidx    = '0;
        for (int i = 0; i < N; i++) begin
            c = int'(ptr) + i;
            if (c >= N) begin
                c = c - N;
            end
            cidx = c[IDX_W-1:0];
            if (!found && req[cidx]) begin
                found         = 1'b1;
                gnt_oh[cidx]  = 1'b1;
                gnt_idx       = cidx;
            end
        end
    end

endmodule

// File: rtl/rd_port_arbiter.sv
// Shares each source cache read port among the output modules: per-source
// round-robin lock with watchdog, read-enable steering and data return mux.
module rd_port_arbiter
    import rd_port_arbiter_pkg::*;
#(
    parameter int REQ_NUB    = 4,
    parameter int SRC_NUB    = PORT_NUB_TOTAL,
    parameter int DATA_WIDTH = PKG_DATA_WIDTH,
    parameter int TIMEOUT    = 1024,
    parameter int WIDTH_SEL  = $clog2(SRC_NUB)
) (
    input  logic                          internal_clk,
    input  logic                          rst_n,
    input  logic [REQ_NUB-1:0]            req_en,
    input  logic [REQ_NUB*WIDTH_SEL-1:0]  req_sel,
    input  logic [REQ_NUB-1:0]            req_rd,
    input  logic [REQ_NUB-1:0]            req_done,
    output logic [REQ_NUB-1:0]            gnt,
    output logic [REQ_NUB*DATA_WIDTH-1:0] rd_data,
    output logic [REQ_NUB-1:0]            rd_vld,
    output logic [SRC_NUB-1:0]            src_rd_en,
    input  logic [SRC_NUB*DATA_WIDTH-1:0] src_data,
    output logic                          timeout_err,
    output logic [SRC_NUB-1:0]            src_locked
);

    localparam int IDX_W = idx_width(REQ_NUB);
    localparam int WD_W  = idx_width(TIMEOUT);

    logic [WIDTH_SEL-1:0]     sel_a [REQ_NUB];
    logic [SRC_NUB-1:0]       locked_vec;
    logic [SRC_NUB*IDX_W-1:0] owner_flat;
    logic [SRC_NUB-1:0]       to_hit;
    logic [WIDTH_SEL-1:0]     rd_sel_d [REQ_NUB];

    always_comb begin
        for (int r = 0; r < REQ_NUB; r++) begin
            sel_a[r] = req_sel[r*WIDTH_SEL +: WIDTH_SEL];
        end
    end

    // Grants are derived purely from registered lock state, so they never
    // depend combinationally on this cycle's requests.
    always_comb begin
        gnt = '0;
        for (int s = 0; s < SRC_NUB; s++) begin
            for (int r = 0; r < REQ_NUB; r++) begin
                if (locked_vec[s] && (owner_flat[s*IDX_W +: IDX_W] == IDX_W'(r))) begin
                    gnt[r] = 1'b1;
                end
            end
        end
    end

    generate
        for (genvar s = 0; s < SRC_NUB; s++) begin : g_src
            src_state_e       state_q, state_d;
            logic [IDX_W-1:0] owner_q, owner_d;
            logic [IDX_W-1:0] ptr_q, ptr_d;
            logic [WD_W-1:0]  wd_q, wd_d;
            logic [REQ_NUB-1:0] cand, win_oh;
            logic [IDX_W-1:0] win_idx;
            logic             release_c, hit_c, rd_en_c;

            always_comb begin
                cand = '0;
                for (int r = 0; r < REQ_NUB; r++) begin
                    cand[r] = req_en[r] && (sel_a[r] == WIDTH_SEL'(s)) && !gnt[r];
                end
            end

            rr_arbiter #(
                .N     (REQ_NUB),
                .IDX_W (IDX_W)
            ) u_rr (
                .req     (cand),
                .ptr     (ptr_q),
                .gnt_oh  (win_oh),
                .gnt_idx (win_idx)
            );

            always_ff @(posedge internal_clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_q <= SRC_FREE;
                    owner_q <= '0;
                    ptr_q   <= '0;
                    wd_q    <= '0;
                end else begin
                    state_q <= state_d;
                    owner_q <= owner_d;
                    ptr_q   <= ptr_d;
                    wd_q    <= wd_d;
                end
            end

            always_comb begin
                state_d   = state_q;
                owner_d   = owner_q;
                ptr_d     = ptr_q;
                wd_d      = wd_q;
                hit_c     = 1'b0;
                release_c = 1'b0;
                rd_en_c   = 1'b0;
                case (state_q)
                    SRC_FREE: begin
                        if (|win_oh) begin
                            state_d = SRC_LOCKED;
                            owner_d = win_idx;
                            ptr_d   = (win_idx == IDX_W'(REQ_NUB - 1)) ? '0 : win_idx + 1'b1;
                            wd_d    = '0;
                        end
                    end
                    SRC_LOCKED: begin
                        rd_en_c   = req_rd[owner_q] && req_en[owner_q];
                        hit_c     = (wd_q == WD_W'(TIMEOUT - 1));
                        release_c = req_done[owner_q] || !req_en[owner_q] ||
                                    (sel_a[owner_q] != WIDTH_SEL'(s)) || hit_c;
                        // The watchdog holds its last value once the lock is dropped.
                        wd_d      = release_c ? wd_q : wd_q + 1'b1;
                        if (release_c) begin
                            state_d = SRC_FREE;
                        end
                    end
                    default: state_d = SRC_FREE;
                endcase
            end

            assign locked_vec[s]                  = (state_q == SRC_LOCKED);
            assign owner_flat[s*IDX_W +: IDX_W]   = owner_q;
            assign to_hit[s]                      = hit_c;
            assign src_rd_en[s]                   = rd_en_c;
        end
    endgenerate

    assign timeout_err = |to_hit;
    assign src_locked  = locked_vec;

    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld <= '0;
            for (int r = 0; r < REQ_NUB; r++) begin
                rd_sel_d[r] <= '0;
            end
        end else begin
            rd_vld <= gnt & req_rd;
            for (int r = 0; r < REQ_NUB; r++) begin
                rd_sel_d[r] <= sel_a[r];
            end
        end
    end

    // Data is zeroed when not valid so idle requesters see a clean bus.
    always_comb begin
        rd_data = '0;
        for (int r = 0; r < REQ_NUB; r++) begin
            if (rd_vld[r]) begin
                rd_data[r*DATA_WIDTH +: DATA_WIDTH] = src_data[rd_sel_d[r]*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

endmodule
